// File: rtl/alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : alu_share_arbiter (with alu_share_arbiter_pkg)
// Purpose  : Shares one combinational ALU between two requesters. A granted
//            request is registered into an issue stage that drives the ALU.
//            The ALU result is then captured into a per-port response
//            register. Both sides use valid/ready handshakes.
// Revision : 1.0 - initial release
// ============================================================================

package alu_share_arbiter_pkg;
    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_XOR  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_AND  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLTS = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_EQ   = 4'd10,
        ALU_NE   = 4'd11
    } alu_opcode_e;
endpackage

module alu_share_arbiter
    import alu_share_arbiter_pkg::*;
#(
    parameter int FIXED_PRIO = 0,
    parameter int XLEN       = 32
) (
    input  logic              clk,
    input  logic              reset_n,
    // request side
    input  logic [1:0]        req_valid_ip,
    output logic [1:0]        req_ready_op,
    input  alu_opcode_e       req0_operator_ip,
    input  logic [XLEN-1:0]   req0_operand_a_ip,
    input  logic [XLEN-1:0]   req0_operand_b_ip,
    input  alu_opcode_e       req1_operator_ip,
    input  logic [XLEN-1:0]   req1_operand_a_ip,
    input  logic [XLEN-1:0]   req1_operand_b_ip,
    // response side
    output logic [1:0]        resp_valid_op,
    input  logic [1:0]        resp_ready_ip,
    output logic [XLEN-1:0]   resp0_result_op,
    output logic [XLEN-1:0]   resp1_result_op,
    output logic [1:0]        resp_error_op,
    // ALU side
    output logic              alu_enable_op,
    output alu_opcode_e       alu_operator_op,
    output logic [XLEN-1:0]   alu_operand_a_op,
    output logic [XLEN-1:0]   alu_operand_b_op,
    input  logic [XLEN-1:0]   alu_result_ip,
    input  logic              alu_valid_ip
);

    // issue stage
    logic            iss_valid_q, iss_valid_d;
    logic            iss_id_q,    iss_id_d;
    alu_opcode_e     iss_op_q,    iss_op_d;
    logic [XLEN-1:0] iss_a_q,     iss_a_d;
    logic [XLEN-1:0] iss_b_q,     iss_b_d;
    logic            rr_last_q,   rr_last_d;

    // response registers
    logic [1:0]      resp_valid_q, resp_valid_d;
    logic [1:0]      resp_error_q, resp_error_d;
    logic [XLEN-1:0] resp_result_q [2];
    logic [XLEN-1:0] resp_result_d [2];

    // handshake helpers
    logic [1:0]      pop;
    logic [1:0]      grant;
    logic            drain;
    logic            iss_free;
    logic            accept;
    logic            acc_id;

    assign pop      = resp_valid_q & resp_ready_ip;
    // The issue stage can only retire into its own port's slot; if that slot
    // is full and not being popped, the whole stage (both ports) stalls.
    assign drain    = iss_valid_q & (~resp_valid_q[iss_id_q] | pop[iss_id_q]);
    assign iss_free = ~iss_valid_q | drain;

    generate
        if (FIXED_PRIO != 0) begin : g_fixed_prio
            // Port 0 always wins when it asks.
            always_comb begin
                grant = 2'b00;
                if (req_valid_ip[0])      grant = 2'b01;
                else if (req_valid_ip[1]) grant = 2'b10;
            end
        end else begin : g_round_robin
            // Single requester wins; on a tie the port not granted last wins.
            always_comb begin
                grant = 2'b00;
                case (req_valid_ip)
                    2'b01:   grant = 2'b01;
                    2'b10:   grant = 2'b10;
                    2'b11:   grant = rr_last_q ? 2'b01 : 2'b10;
                    default: grant = 2'b00;
                endcase
            end
        end
    endgenerate

    // grant is one-hot and only set for a valid port, so ready implies accept
    assign req_ready_op = grant & {2{iss_free}};
    assign accept       = |(req_valid_ip & req_ready_op);
    assign acc_id       = req_ready_op[1];

    // Issue stage next state: load on accept, empty on drain without refill.
    always_comb begin
        iss_valid_d = iss_valid_q;
        iss_id_d    = iss_id_q;
        iss_op_d    = iss_op_q;
        iss_a_d     = iss_a_q;
        iss_b_d     = iss_b_q;
        rr_last_d   = rr_last_q;
        if (accept) begin
            iss_valid_d = 1'b1;
            iss_id_d    = acc_id;
            iss_op_d    = acc_id ? req1_operator_ip  : req0_operator_ip;
            iss_a_d     = acc_id ? req1_operand_a_ip : req0_operand_a_ip;
            iss_b_d     = acc_id ? req1_operand_b_ip : req0_operand_b_ip;
            rr_last_d   = acc_id;
        end else if (drain) begin
            iss_valid_d = 1'b0;
        end
    end

    // Response slots: a drain refills its slot (even while being popped),
    // otherwise a pop empties it. Data is retained after a pop.
    always_comb begin
        resp_valid_d     = resp_valid_q;
        resp_error_d     = resp_error_q;
        resp_result_d[0] = resp_result_q[0];
        resp_result_d[1] = resp_result_q[1];
        for (int i = 0; i < 2; i++) begin
            if (drain && (iss_id_q == 1'(i))) begin
                resp_valid_d[i]  = 1'b1;
                resp_error_d[i]  = ~alu_valid_ip;
                resp_result_d[i] = alu_valid_ip ? alu_result_ip : '0;
            end else if (pop[i]) begin
                resp_valid_d[i]  = 1'b0;
            end
        end
    end

    // Issue stage and arbitration history registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            iss_valid_q <= 1'b0;
            iss_id_q    <= 1'b0;
            iss_op_q    <= ALU_ADD;
            iss_a_q     <= '0;
            iss_b_q     <= '0;
            rr_last_q   <= 1'b1;
        end else begin
            iss_valid_q <= iss_valid_d;
            iss_id_q    <= iss_id_d;
            iss_op_q    <= iss_op_d;
            iss_a_q     <= iss_a_d;
            iss_b_q     <= iss_b_d;
            rr_last_q   <= rr_last_d;
        end
    end

    // Response registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            resp_valid_q     <= 2'b00;
            resp_error_q     <= 2'b00;
            resp_result_q[0] <= '0;
            resp_result_q[1] <= '0;
        end else begin
            resp_valid_q     <= resp_valid_d;
            resp_error_q     <= resp_error_d;
            resp_result_q[0] <= resp_result_d[0];
            resp_result_q[1] <= resp_result_d[1];
        end
    end

    assign alu_enable_op    = iss_valid_q;
    assign alu_operator_op  = iss_op_q;
    assign alu_operand_a_op = iss_a_q;
    assign alu_operand_b_op = iss_b_q;

    assign resp_valid_op    = resp_valid_q;
    assign resp_error_op    = resp_error_q;
    assign resp0_result_op  = resp_result_q[0];
    assign resp1_result_op  = resp_result_q[1];

endmodule

`default_nettype wire

// File: tb/tb_alu_share_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_alu_share_arbiter
// Purpose  : Directed self-checking bench for alu_share_arbiter. A round-robin
//            and a fixed-priority instance share one stimulus set; each has
//            its own small ALU model on the ALU-side ports.
// Revision : 1.0 - initial release
// ============================================================================

module tb_alu_share_arbiter;
    import alu_share_arbiter_pkg::*;

    localparam int XLEN = 32;

    logic            clk;
    logic            reset_n;
    logic [1:0]      req_valid;
    alu_opcode_e     req0_op, req1_op;
    logic [XLEN-1:0] req0_a, req0_b, req1_a, req1_b;
    logic [1:0]      resp_ready;

    // round-robin instance
    logic [1:0]      rr_req_ready, rr_resp_valid, rr_resp_error;
    logic [XLEN-1:0] rr_resp0, rr_resp1, rr_alu_a, rr_alu_b, rr_alu_result;
    logic            rr_alu_enable, rr_alu_valid;
    alu_opcode_e     rr_alu_op;

    // fixed-priority instance
    logic [1:0]      fp_req_ready, fp_resp_valid, fp_resp_error;
    logic [XLEN-1:0] fp_resp0, fp_resp1, fp_alu_a, fp_alu_b, fp_alu_result;
    logic            fp_alu_enable, fp_alu_valid;
    alu_opcode_e     fp_alu_op;

    int n_cmp = 0;
    int n_err = 0;

    // Bench ALU: ALU_NE and the shifts/compares other than SLTS/SLTU are
    // treated as unsupported so the error path can be exercised.
    function automatic logic [XLEN-1:0] alu_f(alu_opcode_e op, logic [XLEN-1:0] a, logic [XLEN-1:0] b);
        case (op)
            ALU_ADD:  return a + b;
            ALU_SUB:  return a - b;
            ALU_XOR:  return a ^ b;
            ALU_OR:   return a | b;
            ALU_AND:  return a & b;
            ALU_SLTS: return {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            ALU_SLTU: return {{(XLEN-1){1'b0}}, (a < b)};
            default:  return 32'hDEAD_BEEF;
        endcase
    endfunction

    function automatic logic alu_ok(alu_opcode_e op);
        return (op == ALU_ADD) || (op == ALU_SUB) || (op == ALU_XOR) || (op == ALU_OR) ||
               (op == ALU_AND) || (op == ALU_SLTS) || (op == ALU_SLTU);
    endfunction

    always_comb begin
        rr_alu_result = alu_f(rr_alu_op, rr_alu_a, rr_alu_b);
        rr_alu_valid  = alu_ok(rr_alu_op);
        fp_alu_result = alu_f(fp_alu_op, fp_alu_a, fp_alu_b);
        fp_alu_valid  = alu_ok(fp_alu_op);
    end

    alu_share_arbiter #(.FIXED_PRIO(0), .XLEN(XLEN)) dut_rr (
        .clk(clk), .reset_n(reset_n),
        .req_valid_ip(req_valid), .req_ready_op(rr_req_ready),
        .req0_operator_ip(req0_op), .req0_operand_a_ip(req0_a), .req0_operand_b_ip(req0_b),
        .req1_operator_ip(req1_op), .req1_operand_a_ip(req1_a), .req1_operand_b_ip(req1_b),
        .resp_valid_op(rr_resp_valid), .resp_ready_ip(resp_ready),
        .resp0_result_op(rr_resp0), .resp1_result_op(rr_resp1), .resp_error_op(rr_resp_error),
        .alu_enable_op(rr_alu_enable), .alu_operator_op(rr_alu_op),
        .alu_operand_a_op(rr_alu_a), .alu_operand_b_op(rr_alu_b),
        .alu_result_ip(rr_alu_result), .alu_valid_ip(rr_alu_valid)
    );

    alu_share_arbiter #(.FIXED_PRIO(1), .XLEN(XLEN)) dut_fp (
        .clk(clk), .reset_n(reset_n),
        .req_valid_ip(req_valid), .req_ready_op(fp_req_ready),
        .req0_operator_ip(req0_op), .req0_operand_a_ip(req0_a), .req0_operand_b_ip(req0_b),
        .req1_operator_ip(req1_op), .req1_operand_a_ip(req1_a), .req1_operand_b_ip(req1_b),
        .resp_valid_op(fp_resp_valid), .resp_ready_ip(resp_ready),
        .resp0_result_op(fp_resp0), .resp1_result_op(fp_resp1), .resp_error_op(fp_resp_error),
        .alu_enable_op(fp_alu_enable), .alu_operator_op(fp_alu_op),
        .alu_operand_a_op(fp_alu_a), .alu_operand_b_op(fp_alu_b),
        .alu_result_ip(fp_alu_result), .alu_valid_ip(fp_alu_valid)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Advance to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        reset_n    = 1'b0;
        req_valid  = 2'b00;
        resp_ready = 2'b00;
        req0_op = ALU_ADD; req0_a = '0; req0_b = '0;
        req1_op = ALU_ADD; req1_a = '0; req1_b = '0;
        repeat (2) @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (rr_resp_valid !== 2'b00) begin n_err++; $display("FAIL rst_resp_valid: got %b want 00", rr_resp_valid); end
        n_cmp++; if (rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL rst_alu_enable: got %b want 0", rr_alu_enable); end
        n_cmp++; if (rr_alu_op !== ALU_ADD) begin n_err++; $display("FAIL rst_alu_op: got %0d want %0d", rr_alu_op, ALU_ADD); end
        n_cmp++; if ({rr_alu_a, rr_alu_b} !== 64'd0) begin n_err++; $display("FAIL rst_operands: got %h/%h want 0/0", rr_alu_a, rr_alu_b); end
        n_cmp++; if ({rr_resp0, rr_resp1} !== 64'd0) begin n_err++; $display("FAIL rst_results: got %h/%h want 0/0", rr_resp0, rr_resp1); end
        n_cmp++; if (rr_resp_error !== 2'b00) begin n_err++; $display("FAIL rst_error: got %b want 00", rr_resp_error); end
        n_cmp++; if (rr_req_ready !== 2'b00) begin n_err++; $display("FAIL rst_ready_idle: got %b want 00", rr_req_ready); end
        n_cmp++; if (fp_alu_enable !== 1'b0) begin n_err++; $display("FAIL rst_fp_enable: got %b want 0", fp_alu_enable); end
    endtask

    task automatic test_single();
        do_reset();
        resp_ready = 2'b11;
        req0_op = ALU_ADD; req0_a = 32'd5; req0_b = 32'd7;
        req_valid = 2'b01;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b01) begin n_err++; $display("FAIL single_ready: got %b want 01", rr_req_ready); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if (rr_alu_enable !== 1'b1) begin n_err++; $display("FAIL single_enable: got %b want 1", rr_alu_enable); end
        n_cmp++; if (rr_alu_op !== ALU_ADD || rr_alu_a !== 32'd5 || rr_alu_b !== 32'd7) begin n_err++; $display("FAIL single_alu_in: got %0d %0d %0d want 0 5 7", rr_alu_op, rr_alu_a, rr_alu_b); end
        n_cmp++; if (rr_resp_valid !== 2'b00) begin n_err++; $display("FAIL single_early_valid: got %b want 00", rr_resp_valid); end
        tick();
        n_cmp++; if (rr_resp_valid !== 2'b01) begin n_err++; $display("FAIL single_resp_valid: got %b want 01", rr_resp_valid); end
        n_cmp++; if (rr_resp0 !== 32'd12) begin n_err++; $display("FAIL single_result: got %0d want 12", rr_resp0); end
        n_cmp++; if (rr_resp_error !== 2'b00) begin n_err++; $display("FAIL single_error: got %b want 00", rr_resp_error); end
        n_cmp++; if (rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL single_idle: got %b want 0", rr_alu_enable); end
        tick();
        n_cmp++; if (rr_resp_valid !== 2'b00) begin n_err++; $display("FAIL single_popped: got %b want 00", rr_resp_valid); end
    endtask

    task automatic test_round_robin();
        logic [1:0] exp_rdy [4];
        exp_rdy[0] = 2'b01; exp_rdy[1] = 2'b10; exp_rdy[2] = 2'b01; exp_rdy[3] = 2'b10;
        do_reset();
        resp_ready = 2'b11;
        req0_op = ALU_SUB;  req0_a = 32'd10;         req0_b = 32'd3;
        req1_op = ALU_SLTS; req1_a = 32'hFFFF_FFFF;  req1_b = 32'd1;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            if (i == 2) begin
                n_cmp++; if (rr_resp_valid[0] !== 1'b1 || rr_resp0 !== 32'd7) begin n_err++; $display("FAIL rr_result0: got v=%b %0d want v=1 7", rr_resp_valid[0], rr_resp0); end
            end
            if (i == 3) begin
                n_cmp++; if (rr_resp_valid[1] !== 1'b1 || rr_resp1 !== 32'd1) begin n_err++; $display("FAIL rr_result1: got v=%b %0d want v=1 1", rr_resp_valid[1], rr_resp1); end
            end
            #1;
            n_cmp++; if (rr_req_ready !== exp_rdy[i]) begin n_err++; $display("FAIL rr_grant_%0d: got %b want %b", i, rr_req_ready, exp_rdy[i]); end
            tick();
        end
        req_valid = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_fixed_prio();
        int p1_grants;
        p1_grants = 0;
        do_reset();
        resp_ready = 2'b11;
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd1;
        req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2;
        req_valid = 2'b11;
        for (int i = 0; i < 4; i++) begin
            #1;
            if (fp_req_ready[1]) p1_grants++;
            n_cmp++; if (fp_req_ready !== 2'b01) begin n_err++; $display("FAIL fp_grant_%0d: got %b want 01", i, fp_req_ready); end
            tick();
        end
        n_cmp++; if (p1_grants !== 0) begin n_err++; $display("FAIL fp_port1_starved: got %0d grants want 0", p1_grants); end
        req_valid = 2'b10;
        #1;
        n_cmp++; if (fp_req_ready !== 2'b10) begin n_err++; $display("FAIL fp_port1_after_drop: got %b want 10", fp_req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (3) tick();
    endtask

    task automatic test_backpressure();
        do_reset();
        resp_ready = 2'b10;
        req0_op = ALU_ADD; req0_a = 32'd1; req0_b = 32'd2;
        req_valid = 2'b01;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b01) begin n_err++; $display("FAIL bp_accept1: got %b want 01", rr_req_ready); end
        tick();
        req0_a = 32'd3; req0_b = 32'd4;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b01) begin n_err++; $display("FAIL bp_accept2: got %b want 01", rr_req_ready); end
        tick();
        req_valid = 2'b10;
        req1_op = ALU_ADD; req1_a = 32'd100; req1_b = 32'd200;
        for (int i = 0; i < 2; i++) begin
            #1;
            n_cmp++; if (rr_req_ready !== 2'b00) begin n_err++; $display("FAIL bp_stall_ready_%0d: got %b want 00", i, rr_req_ready); end
            n_cmp++; if (rr_alu_enable !== 1'b1 || rr_alu_a !== 32'd3 || rr_alu_b !== 32'd4) begin n_err++; $display("FAIL bp_stall_alu_%0d: got en=%b %0d %0d want en=1 3 4", i, rr_alu_enable, rr_alu_a, rr_alu_b); end
            n_cmp++; if (rr_resp_valid !== 2'b01 || rr_resp0 !== 32'd3) begin n_err++; $display("FAIL bp_held_%0d: got v=%b %0d want v=01 3", i, rr_resp_valid, rr_resp0); end
            tick();
        end
        resp_ready = 2'b11;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b10) begin n_err++; $display("FAIL bp_release_ready: got %b want 10", rr_req_ready); end
        tick();
        req_valid = 2'b00;
        n_cmp++; if (rr_resp_valid[0] !== 1'b1 || rr_resp0 !== 32'd7) begin n_err++; $display("FAIL bp_second: got v=%b %0d want v=1 7", rr_resp_valid[0], rr_resp0); end
        n_cmp++; if (rr_alu_a !== 32'd100 || rr_alu_enable !== 1'b1) begin n_err++; $display("FAIL bp_port1_issue: got en=%b %0d want en=1 100", rr_alu_enable, rr_alu_a); end
        tick();
        n_cmp++; if (rr_resp_valid !== 2'b10 || rr_resp1 !== 32'd300) begin n_err++; $display("FAIL bp_port1_resp: got v=%b %0d want v=10 300", rr_resp_valid, rr_resp1); end
        repeat (2) tick();
    endtask

    task automatic test_unsupported();
        do_reset();
        resp_ready = 2'b11;
        req1_op = ALU_NE; req1_a = 32'd9; req1_b = 32'd9;
        req_valid = 2'b10;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b10) begin n_err++; $display("FAIL unsup_ready: got %b want 10", rr_req_ready); end
        tick();
        req_valid = 2'b00;
        tick();
        n_cmp++; if (rr_resp_valid !== 2'b10 || rr_resp_error !== 2'b10) begin n_err++; $display("FAIL unsup_flag: got v=%b e=%b want v=10 e=10", rr_resp_valid, rr_resp_error); end
        n_cmp++; if (rr_resp1 !== 32'd0) begin n_err++; $display("FAIL unsup_result: got %h want 0", rr_resp1); end
        tick();
        n_cmp++; if (rr_resp_valid !== 2'b00) begin n_err++; $display("FAIL unsup_popped: got %b want 00", rr_resp_valid); end
        req1_op = ALU_ADD; req1_a = 32'd2; req1_b = 32'd2;
        req_valid = 2'b10;
        tick();
        req_valid = 2'b00;
        tick();
        n_cmp++; if (rr_resp_error !== 2'b00 || rr_resp1 !== 32'd4) begin n_err++; $display("FAIL unsup_recover: got e=%b %0d want e=00 4", rr_resp_error, rr_resp1); end
        tick();
    endtask

    task automatic test_reset_mid();
        do_reset();
        resp_ready = 2'b00;
        req1_op = ALU_ADD; req1_a = 32'd1; req1_b = 32'd1;
        req_valid = 2'b10;
        tick();
        req1_a = 32'd5; req1_b = 32'd5;
        tick();
        req_valid = 2'b00;
        n_cmp++; if (rr_alu_enable !== 1'b1 || rr_resp_valid !== 2'b10) begin n_err++; $display("FAIL rmid_setup: got en=%b v=%b want en=1 v=10", rr_alu_enable, rr_resp_valid); end
        #2;
        reset_n = 1'b0;
        #1;
        n_cmp++; if (rr_resp_valid !== 2'b00 || rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL rmid_async: got v=%b en=%b want v=00 en=0", rr_resp_valid, rr_alu_enable); end
        n_cmp++; if (rr_resp1 !== 32'd0) begin n_err++; $display("FAIL rmid_result: got %0d want 0", rr_resp1); end
        tick();
        reset_n = 1'b1;
        resp_ready = 2'b11;
        repeat (2) begin
            tick();
            n_cmp++; if (rr_resp_valid !== 2'b00 || rr_alu_enable !== 1'b0) begin n_err++; $display("FAIL rmid_stale: got v=%b en=%b want v=00 en=0", rr_resp_valid, rr_alu_enable); end
        end
        req_valid = 2'b11;
        #1;
        n_cmp++; if (rr_req_ready !== 2'b01) begin n_err++; $display("FAIL rmid_first_tie: got %b want 01", rr_req_ready); end
        tick();
        req_valid = 2'b00;
        repeat (2) tick();
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_fixed_prio();
        test_backpressure();
        test_unsupported();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

`default_nettype wire
